// File: rtl/mm_tile_ctrl.sv
// mm_tile_ctrl: sequencer for a row-major C = A x B matrix-multiply datapath.
// Walks the output in blocks of LANES adjacent columns. For each block it
// clears the lane accumulators and streams dim1 A/B reads. It then presents
// one C write with a mask for the partial last block of a row.
// A stall freezes INIT/MAC/WB. Bad or overflowing dimensions reject the job.

// Per-lane column-valid bit: lane IDX is live when j0+IDX lies inside dim2.
module mm_tile_lane #(
    parameter int N   = 8,
    parameter int IDX = 0
) (
    input  logic [N-1:0] j0,
    input  logic [N-1:0] dim2,
    output logic         active
);
    // wide compare so j0+IDX never wraps
    localparam int W = N + 32;

    assign active = (W'(j0) + W'(IDX)) < W'(dim2);
endmodule

module mm_tile_ctrl #(
    parameter int N     = 8,
    parameter int M     = 16,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     dim0,
    input  logic [N-1:0]     dim1,
    input  logic [N-1:0]     dim2,
    input  logic             stall,
    output logic             loaddim,
    output logic [M-1:0]     aadr,
    output logic [M-1:0]     badr,
    output logic             abufread,
    output logic             bbufread,
    output logic             init0reg,
    output logic             ldreg,
    output logic             valid,
    output logic [M-1:0]     cadr,
    output logic [LANES-1:0] lane_mask,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CHECK, S_INIT, S_MAC, S_WB, S_DONE
    } state_t;

    // product width: wide enough for a full dim*dim product and for 2^M itself
    localparam int PW = (2 * N > M + 1) ? 2 * N : M + 1;
    localparam int JW = N + 32;

    state_t state, nstate;

    logic [N-1:0] d0, d1, d2;      // dims latched in LOAD
    logic [N-1:0] i, j0, k;        // row, first column of block, inner index
    logic [M-1:0] a_row;           // i*dim1
    logic [M-1:0] c_row;           // i*dim2
    logic [M-1:0] a_ptr;           // i*dim1 + k
    logic [M-1:0] b_ptr;           // k*dim2 + j0
    logic         err_q;

    logic [PW-1:0]    p01, p12, p02, lim;
    logic             dim_bad;
    logic             last_col, last_row, k_last;
    logic [LANES-1:0] mask_raw;

    assign p01 = PW'(d0) * PW'(d1);
    assign p12 = PW'(d1) * PW'(d2);
    assign p02 = PW'(d0) * PW'(d2);
    assign lim = PW'(1) << M;

    assign dim_bad = (d0 == '0) || (d1 == '0) || (d2 == '0) ||
                     (p01 > lim) || (p12 > lim) || (p02 > lim);

    assign last_col = (JW'(j0) + JW'(LANES)) >= JW'(d2);
    assign last_row = (i == d0 - N'(1));
    assign k_last   = (k == d1 - N'(1));

    // one mask bit per lane, each from its own lane instance
    genvar l;
    generate
        for (l = 0; l < LANES; l++) begin : g_lane
            mm_tile_lane #(.N(N), .IDX(l)) u_lane (
                .j0    (j0),
                .dim2  (d2),
                .active(mask_raw[l])
            );
        end
    endgenerate

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= nstate;
    end

    // next-state and strobe decode; stall suppresses strobes and holds state
    always_comb begin
        nstate   = state;
        loaddim  = 1'b0;
        abufread = 1'b0;
        bbufread = 1'b0;
        init0reg = 1'b0;
        ldreg    = 1'b0;
        valid    = 1'b0;
        done     = 1'b0;
        unique case (state)
            S_IDLE:  if (start) nstate = S_LOAD;
            S_LOAD: begin
                loaddim = 1'b1;
                nstate  = S_CHECK;
            end
            S_CHECK: nstate = dim_bad ? S_DONE : S_INIT;
            S_INIT: begin
                if (!stall) begin
                    init0reg = 1'b1;
                    nstate   = S_MAC;
                end
            end
            S_MAC: begin
                if (!stall) begin
                    abufread = 1'b1;
                    bbufread = 1'b1;
                    ldreg    = 1'b1;
                    if (k_last) nstate = S_WB;
                end
            end
            S_WB: begin
                valid = 1'b1;
                if (!stall) nstate = (last_row && last_col) ? S_DONE : S_INIT;
            end
            S_DONE: begin
                done   = 1'b1;
                nstate = S_IDLE;
            end
            default: nstate = S_IDLE;
        endcase
    end

    // counters and incremental address bases; all hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            d0    <= '0;
            d1    <= '0;
            d2    <= '0;
            i     <= '0;
            j0    <= '0;
            k     <= '0;
            a_row <= '0;
            c_row <= '0;
            a_ptr <= '0;
            b_ptr <= '0;
            err_q <= 1'b0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    d0    <= dim0;
                    d1    <= dim1;
                    d2    <= dim2;
                    err_q <= 1'b0;
                end
                S_CHECK: begin
                    err_q <= dim_bad;
                    i     <= '0;
                    j0    <= '0;
                    k     <= '0;
                    a_row <= '0;
                    c_row <= '0;
                end
                S_INIT: begin
                    if (!stall) begin
                        k     <= '0;
                        a_ptr <= a_row;
                        b_ptr <= M'(j0);
                    end
                end
                S_MAC: begin
                    if (!stall) begin
                        k     <= k + N'(1);
                        a_ptr <= a_ptr + M'(1);
                        b_ptr <= b_ptr + M'(d2);
                    end
                end
                S_WB: begin
                    if (!stall) begin
                        if (last_col) begin
                            j0    <= '0;
                            i     <= i + N'(1);
                            a_row <= a_row + M'(d1);
                            c_row <= c_row + M'(d2);
                        end else begin
                            j0 <= j0 + N'(LANES);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign aadr      = a_ptr;
    assign badr      = b_ptr;
    assign cadr      = (state == S_WB) ? (c_row + M'(j0)) : '0;
    assign lane_mask = (state == S_WB) ? mask_raw : '0;
    assign busy      = (state != S_IDLE);
    assign err       = err_q;
endmodule

// File: tb/tb_mm_tile_ctrl.sv
// Directed bench for mm_tile_ctrl: reset, small and blocked jobs, rejects,
// stalls, and a mid-job reset. A second instance with M=8 covers overflow.
module tb_mm_tile_ctrl;
    localparam int N = 8;
    localparam int M = 16;
    localparam int L = 4;

    logic clk = 1'b0;
    logic rst, start, stall;
    logic [N-1:0] dim0, dim1, dim2;

    logic         loaddim0, abuf0, bbuf0, init0, ld0, valid0, busy0, done0, err0;
    logic [M-1:0] aadr0, badr0, cadr0;
    logic [L-1:0] mask0;
    logic         loaddim1, abuf1, bbuf1, init1, ld1, valid1, busy1, done1, err1;
    logic [7:0]   aadr1, badr1, cadr1;
    logic [L-1:0] mask1;

    always #5 clk = ~clk;

    mm_tile_ctrl #(.N(N), .M(M), .LANES(L)) dut (
        .clk(clk), .rst(rst), .start(start), .dim0(dim0), .dim1(dim1), .dim2(dim2),
        .stall(stall), .loaddim(loaddim0), .aadr(aadr0), .badr(badr0),
        .abufread(abuf0), .bbufread(bbuf0), .init0reg(init0), .ldreg(ld0),
        .valid(valid0), .cadr(cadr0), .lane_mask(mask0), .busy(busy0),
        .done(done0), .err(err0)
    );

    mm_tile_ctrl #(.N(N), .M(8), .LANES(L)) dut8 (
        .clk(clk), .rst(rst), .start(start), .dim0(dim0), .dim1(dim1), .dim2(dim2),
        .stall(stall), .loaddim(loaddim1), .aadr(aadr1), .badr(badr1),
        .abufread(abuf1), .bbufread(bbuf1), .init0reg(init1), .ldreg(ld1),
        .valid(valid1), .cadr(cadr1), .lane_mask(mask1), .busy(busy1),
        .done(done1), .err(err1)
    );

    // observed outputs of the selected instance
    int sel;
    logic         o_loaddim, o_abuf, o_bbuf, o_init, o_ld, o_valid, o_busy, o_done, o_err;
    logic [M-1:0] o_aadr, o_badr, o_cadr;
    logic [L-1:0] o_mask;

    always_comb begin
        if (sel == 1) begin
            o_loaddim = loaddim1; o_abuf = abuf1; o_bbuf = bbuf1; o_init = init1;
            o_ld = ld1; o_valid = valid1; o_busy = busy1; o_done = done1; o_err = err1;
            o_aadr = M'(aadr1); o_badr = M'(badr1); o_cadr = M'(cadr1); o_mask = mask1;
        end else begin
            o_loaddim = loaddim0; o_abuf = abuf0; o_bbuf = bbuf0; o_init = init0;
            o_ld = ld0; o_valid = valid0; o_busy = busy0; o_done = done0; o_err = err0;
            o_aadr = aadr0; o_badr = badr0; o_cadr = cadr0; o_mask = mask0;
        end
    end

    int nchk = 0;
    int nerr = 0;

    // per-job record
    int aq[$], bq[$], cq[$], mq[$], vq[$], exp_q[$];
    int ndone, done_cyc, err_done, ninit, ld_cyc, busy_c1, rd_any, rst_or;

    // expected sequences, hand-derived
    int e235_a[12] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
    int e235_b[12] = '{0, 5, 10, 4, 9, 14, 0, 5, 10, 4, 9, 14};
    int e235_c[12] = '{0, 4, 5, 9, 0, 0, 0, 0, 0, 0, 0, 0};
    int e235_m[12] = '{15, 1, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    int e235_v[12] = '{7, 12, 17, 22, 0, 0, 0, 0, 0, 0, 0, 0};
    int est_c[12]  = '{0, 0, 0, 4, 5, 9, 0, 0, 0, 0, 0, 0};
    int est_m[12]  = '{15, 15, 15, 1, 15, 1, 0, 0, 0, 0, 0, 0};
    int est_v[12]  = '{10, 11, 12, 17, 22, 27, 0, 0, 0, 0, 0, 0};
    int e111_1[12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int e111_0[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int e111_v[12] = '{5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_exp(input int v[12], input int cnt);
        exp_q.delete();
        for (int n = 0; n < cnt; n++) exp_q.push_back(v[n]);
    endtask

    function automatic int qsize(input int s);
        case (s)
            0: return aq.size();
            1: return bq.size();
            2: return cq.size();
            3: return mq.size();
            default: return vq.size();
        endcase
    endfunction

    function automatic int qat(input int s, input int n);
        case (s)
            0: return aq[n];
            1: return bq[n];
            2: return cq[n];
            3: return mq[n];
            default: return vq[n];
        endcase
    endfunction

    task automatic cmp_q(input string tag, input int s);
        int gsz;
        gsz = qsize(s);
        chk({tag, ".len"}, gsz, exp_q.size());
        for (int n = 0; n < exp_q.size() && n < gsz; n++)
            chk($sformatf("%s[%0d]", tag, n), qat(s, n), exp_q[n]);
    endtask

    // Runs ncyc cycles from the current post-edge point; cycle 0 is the first.
    task automatic run(input int which, input int a, input int b, input int c,
                       input logic [63:0] stall_m, input logic [63:0] start_m,
                       input int rst_at, input int ncyc);
        aq.delete(); bq.delete(); cq.delete(); mq.delete(); vq.delete();
        ndone = 0; done_cyc = -1; err_done = -1; ninit = 0; ld_cyc = -1;
        busy_c1 = -1; rd_any = 0; rst_or = -1;
        sel  = which;
        dim0 = N'(a); dim1 = N'(b); dim2 = N'(c);
        for (int cy = 0; cy < ncyc; cy++) begin
            start = (cy < 64) ? start_m[cy[5:0]] : 1'b0;
            stall = (cy < 64) ? stall_m[cy[5:0]] : 1'b0;
            rst   = (cy == rst_at);
            #1;
            if (o_abuf) begin
                aq.push_back(int'(o_aadr));
                bq.push_back(int'(o_badr));
            end
            if (o_abuf || o_bbuf || o_ld) rd_any = 1;
            if (o_valid) begin
                cq.push_back(int'(o_cadr));
                mq.push_back(int'(o_mask));
                vq.push_back(cy);
            end
            if (o_init) ninit++;
            if (o_loaddim) ld_cyc = cy;
            if (cy == 1) busy_c1 = int'(o_busy);
            if (o_done) begin
                ndone++;
                done_cyc = cy;
                err_done = int'(o_err);
            end
            if (cy == rst_at + 1)
                rst_or = int'(|{o_aadr, o_badr, o_cadr, o_mask, o_loaddim, o_abuf, o_bbuf,
                                o_init, o_ld, o_valid, o_busy, o_done, o_err});
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        stall = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        sel = 0; rst = 1'b1; start = 1'b0; stall = 1'b0;
        dim0 = '0; dim1 = '0; dim2 = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // reset state
        chk("rst.aadr", int'(aadr0), 0);
        chk("rst.badr", int'(badr0), 0);
        chk("rst.cadr", int'(cadr0), 0);
        chk("rst.mask", int'(mask0), 0);
        chk("rst.busy", int'(busy0), 0);
        chk("rst.err", int'(err0), 0);
        chk("rst.strobes", int'({loaddim0, abuf0, bbuf0, init0, ld0, valid0, done0}), 0);
        rst = 1'b0;

        // 1x1x1 job
        run(0, 1, 1, 1, 64'h0, 64'h1, -1, 8);
        chk("j111.ld_cyc", ld_cyc, 1);
        chk("j111.busy_c1", busy_c1, 1);
        chk("j111.done_cyc", done_cyc, 6);
        chk("j111.err", err_done, 0);
        chk("j111.ndone", ndone, 1);
        set_exp(e111_0, 1); cmp_q("j111.aadr", 0);
        set_exp(e111_0, 1); cmp_q("j111.badr", 1);
        set_exp(e111_0, 1); cmp_q("j111.cadr", 2);
        set_exp(e111_1, 1); cmp_q("j111.mask", 3);
        set_exp(e111_v, 1); cmp_q("j111.vcyc", 4);

        // 2x3x5 job, two blocks per row with a partial second block
        run(0, 2, 3, 5, 64'h0, 64'h1, -1, 26);
        chk("j235.done_cyc", done_cyc, 23);
        chk("j235.err", err_done, 0);
        chk("j235.ninit", ninit, 4);
        set_exp(e235_a, 12); cmp_q("j235.aadr", 0);
        set_exp(e235_b, 12); cmp_q("j235.badr", 1);
        set_exp(e235_c, 4);  cmp_q("j235.cadr", 2);
        set_exp(e235_m, 4);  cmp_q("j235.mask", 3);
        set_exp(e235_v, 4);  cmp_q("j235.vcyc", 4);

        // zero dimension rejected
        run(0, 2, 0, 5, 64'h0, 64'h1, -1, 6);
        chk("dim0.done_cyc", done_cyc, 3);
        chk("dim0.err", err_done, 1);
        chk("dim0.reads", rd_any, 0);
        chk("dim0.valids", vq.size(), 0);

        // stall 3 cycles mid-MAC (cycles 5-7) and 2 cycles in WB (10-11)
        run(0, 2, 3, 5, 64'h0CE0, 64'h1, -1, 31);
        chk("stall.done_cyc", done_cyc, 28);
        chk("stall.err", err_done, 0);
        set_exp(e235_a, 12); cmp_q("stall.aadr", 0);
        set_exp(e235_b, 12); cmp_q("stall.badr", 1);
        set_exp(est_c, 6);   cmp_q("stall.cadr", 2);
        set_exp(est_m, 6);   cmp_q("stall.mask", 3);
        set_exp(est_v, 6);   cmp_q("stall.vcyc", 4);

        // reset in cycle 10 aborts the job
        run(0, 2, 3, 5, 64'h0, 64'h1, 10, 12);
        chk("midrst.outputs", rst_or, 0);
        chk("midrst.ndone", ndone, 0);

        // restart; extra start pulses while busy are ignored
        run(0, 2, 3, 5, 64'h0, 64'h8021, -1, 30);
        chk("restart.ndone", ndone, 1);
        chk("restart.done_cyc", done_cyc, 23);
        set_exp(e235_c, 4); cmp_q("restart.cadr", 2);

        // M=8 instance: 20*20 = 400 > 256 rejected
        run(1, 20, 20, 1, 64'h0, 64'h1, -1, 6);
        chk("ovf.done_cyc", done_cyc, 3);
        chk("ovf.err", err_done, 1);
        chk("ovf.reads", rd_any, 0);
        chk("ovf.valids", vq.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/mm_tile_ctrl.md
# mm_tile_ctrl

Parametrised sequencer for the matrix-multiply datapath. It computes C = A × B with A of size dim0×dim1 and B of size dim1×dim2, both stored row-major. The block produces A/B buffer addresses and read strobes, drives the accumulator clear/load controls, and emits C write addresses for LANES adjacent output columns per pass. It adds three things the earlier controller lacked: multi-lane column blocking with a partial-block mask, a stall input, and dimension/overflow error reporting.

## Interface
- N, default 8: width of each dimension input.
- M, default 16: address width for A, B and C.
- LANES, default 4: number of output columns (parallel MAC lanes) per pass; must be ≥ 1.

- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a job; sampled only in IDLE.
- dim0, dim1, dim2  in  N each  matrix dimensions; sampled in LOAD.
- stall  in  1  buffer/datapath not ready; freezes the sequencer.
- loaddim  out  1  one-cycle pulse in LOAD.
- aadr  out  M  address of A[i][k].
- badr  out  M  address of B[k][j0]; lane l reads badr+l.
- abufread, bbufread  out  1 each  buffer read strobes.
- init0reg  out  1  clear all lane accumulators.
- ldreg  out  1  accumulate the current products.
- valid  out  1  accumulators hold C[i][j0..j0+LANES-1].
- cadr  out  M  address of C[i][j0].
- lane_mask  out  LANES  bit l = 1 iff j0+l < dim2.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = job rejected.

## Operation
- FSM states: IDLE, LOAD, CHECK, INIT, MAC, WB, DONE.
- IDLE: go to LOAD when start=1; start in any other state is ignored.
- LOAD: latch the dims into internal registers and pulse loaddim. Go to CHECK.
- CHECK: set err if any dim is 0, or if dim0·dim1, dim1·dim2 or dim0·dim2 exceeds 2^M (compare at full 2N-bit width).
  - err=1: go to DONE.
  - Otherwise: set i=0, j0=0, k=0 and go to INIT.
- INIT: init0reg=1, k=0. Go to MAC.
- MAC: abufread=bbufread=ldreg=1.
  - aadr = i·dim1 + k; badr = k·dim2 + j0.
  - Both addresses are maintained incrementally with base registers and adders; no multiplier is used per cycle.
  - k increments each cycle. When k = dim1−1, go to WB.
- WB: valid=1, with cadr = i·dim2 + j0 and lane_mask set.
  - If j0+LANES ≥ dim2: j0←0 and i←i+1; otherwise j0←j0+LANES.
  - If i = dim0−1 and j0+LANES ≥ dim2, go to DONE; else go to INIT.
- DONE: done=1 for one cycle, err is held, then go to IDLE. err clears when the next job reaches LOAD.
- All address arithmetic is modulo 2^M; CHECK guarantees no wrap for accepted jobs.
- Strobes (loaddim, abufread, bbufread, init0reg, ldreg, valid, done) are 0 in every state not listed for them.

## Timing
- Reset: state=IDLE. Every output is 0, including the addresses, lane_mask and err. Internal counters are 0.
- A reset mid-job takes effect on the next edge: abort, no done pulse, outputs return to reset values.
- Latency: start is high in cycle 0 (IDLE). LOAD is cycle 1, CHECK cycle 2, first INIT cycle 3.
  - Each output block takes dim1+2 cycles.
  - Number of blocks B = dim0·ceil(dim2/LANES).
  - done is asserted in cycle 3 + B·(dim1+2).
  - On a rejected job, done and err=1 are asserted in cycle 3.
- Stall applies in INIT, MAC and WB:
  - state, i, j0 and k hold;
  - abufread, bbufread, ldreg and init0reg are forced 0;
  - in WB, valid, cadr and lane_mask stay asserted and stable until the first non-stalled cycle, which is the one accepted.
- Stall is ignored in IDLE, LOAD, CHECK and DONE.
- dim changes after LOAD have no effect on the running job.
- LANES ≥ dim2 gives one block per row. LANES=1 reproduces single-column sequencing.

## Test plan
- dims 1,1,1, LANES=4, start in cycle 0: valid in cycle 5 with cadr=0, lane_mask=0001; done in cycle 6 with err=0.
- dims 2,3,5, LANES=4:
  - first block MAC aadr=0,1,2 and badr=0,5,10; then valid with cadr=0, mask=1111;
  - second block badr=4,9,14; then cadr=4, mask=0001;
  - row 1 blocks give aadr 3,4,5 and cadr=5, then cadr=9;
  - done in cycle 23.
- dim1=0, and separately M=8 with dims 20,20,1: done and err=1 in cycle 3, with no abufread, ldreg or valid.
- dims 2,3,5 with stall high for 3 cycles mid-MAC and 2 cycles in WB: the address sequence is unchanged; valid is held for 3 cycles; done is 5 cycles late (cycle 28).
- rst pulsed in cycle 10 of a 2,3,5 job: all outputs are 0 in cycle 11. A restart then completes normally, and start pulses while busy are ignored (done is asserted exactly once).
